md_flash_seq: RTL and testbench

//  Sequences JEDEC flash command cycles (program word, sector erase, chip erase, reset)

---
 rtl/md_flash_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_md_flash_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_flash_seq.sv
// md_flash_seq: issues JEDEC flash command cycles onto the cart bus and polls DQ7/DQ5
// until the flash reports completion, error or timeout.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | waiting for a command, cmd_ready high
// S_WR        | drive next unlock/command write from the table, raise bus_we
// S_WR_WAIT   | hold the write until bus_ack, then advance or start polling
// S_POLL      | drive poll address, raise bus_oe
// S_POLL_WAIT | hold the read until bus_ack, capture DQ7/DQ5
// S_CHK       | decide finished / confirm read / timeout / poll again
// S_DONE      | one-cycle done pulse, busy drops on exit
module md_flash_seq #(
  parameter logic [22:0] UNLOCK_A1   = 23'h000555,
  parameter logic [22:0] UNLOCK_A2   = 23'h0002AA,
  parameter logic [23:0] TIMEOUT_CYC = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [22:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic [22:0] bus_addr,
  output logic [15:0] bus_wdat,
  output logic        bus_we,
  output logic        bus_oe,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdat,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] OP_PROG  = 2'd0;
  localparam logic [1:0] OP_SECT  = 2'd1;
  localparam logic [1:0] OP_CHIP  = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_WAIT, S_POLL, S_POLL_WAIT, S_CHK, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [1:0]  op_q, op_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [22:0] bus_addr_q, bus_addr_d;
  logic [15:0] bus_wdat_q, bus_wdat_d;
  logic        bus_we_q, bus_we_d;
  logic        bus_oe_q, bus_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        confirm_q, confirm_d;
  logic        q7_q, q7_d;
  logic        q5_q, q5_d;
  // Remaining poll budget; zero means the timeout has been reached.
  logic [23:0] tcnt_q, tcnt_d;

  logic [22:0] tbl_addr;
  logic [15:0] tbl_data;
  logic [2:0]  last_step;
  logic        exp7;
  logic [22:0] poll_addr;

  // Command write table: address/data for the current step of the latched op.
  always_comb begin
    tbl_addr  = UNLOCK_A1;
    tbl_data  = 16'h0000;
    last_step = 3'd5;
    case (op_q)
      OP_PROG: begin
        last_step = 3'd3;
        case (step_q)
          3'd0:    begin tbl_addr = UNLOCK_A1; tbl_data = 16'h00AA; end
          3'd1:    begin tbl_addr = UNLOCK_A2; tbl_data = 16'h0055; end
          3'd2:    begin tbl_addr = UNLOCK_A1; tbl_data = 16'h00A0; end
          default: begin tbl_addr = addr_q;    tbl_data = data_q;   end
        endcase
      end
      OP_RESET: begin
        last_step = 3'd0;
        tbl_addr  = addr_q;
        tbl_data  = 16'h00F0;
      end
      default: begin
        case (step_q)
          3'd0:    begin tbl_addr = UNLOCK_A1; tbl_data = 16'h00AA; end
          3'd1:    begin tbl_addr = UNLOCK_A2; tbl_data = 16'h0055; end
          3'd2:    begin tbl_addr = UNLOCK_A1; tbl_data = 16'h0080; end
          3'd3:    begin tbl_addr = UNLOCK_A1; tbl_data = 16'h00AA; end
          3'd4:    begin tbl_addr = UNLOCK_A2; tbl_data = 16'h0055; end
          default: begin
            if (op_q == OP_CHIP) begin
              tbl_addr = UNLOCK_A1; tbl_data = 16'h0010;
            end else begin
              tbl_addr = addr_q;    tbl_data = 16'h0030;
            end
          end
        endcase
      end
    endcase
  end

  // Programming completes when DQ7 reads back the written bit; erases when DQ7 reads 1.
  assign exp7      = (op_q == OP_PROG) ? data_q[7] : 1'b1;
  assign poll_addr = (op_q == OP_CHIP) ? UNLOCK_A1 : addr_q;

  // Next-state and registered-output logic of the sequencer.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    bus_addr_d = bus_addr_q;
    bus_wdat_d = bus_wdat_q;
    bus_we_d   = bus_we_q;
    bus_oe_d   = bus_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    confirm_d  = confirm_q;
    q7_d       = q7_q;
    q5_d       = q5_q;
    tcnt_d     = tcnt_q;
    if (state_q == S_POLL || state_q == S_POLL_WAIT || state_q == S_CHK) begin
      if (tcnt_q != 24'd0) tcnt_d = tcnt_q - 24'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op;
          addr_d    = cmd_addr;
          data_d    = cmd_data;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          step_d    = 3'd0;
          confirm_d = 1'b0;
          state_d   = S_WR;
        end
      end
      S_WR: begin
        bus_addr_d = tbl_addr;
        bus_wdat_d = tbl_data;
        bus_we_d   = 1'b1;
        state_d    = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (bus_ack) begin
          bus_we_d = 1'b0;
          if (step_q != last_step) begin
            step_d  = step_q + 3'd1;
            state_d = S_WR;
          end else if (op_q == OP_RESET) begin
            done_d  = 1'b1;
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            tcnt_d  = TIMEOUT_CYC;
            state_d = S_POLL;
          end
        end
      end
      S_POLL: begin
        bus_addr_d = poll_addr;
        bus_oe_d   = 1'b1;
        state_d    = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (bus_ack) begin
          bus_oe_d = 1'b0;
          q7_d     = bus_rdat[7];
          q5_d     = bus_rdat[5];
          state_d  = S_CHK;
        end
      end
      S_CHK: begin
        if (q7_q == exp7) begin
          done_d = 1'b1; err_d = 1'b0; state_d = S_DONE;
        end else if (confirm_q) begin
          done_d = 1'b1; err_d = 1'b1; state_d = S_DONE;
        end else if (q5_q) begin
          confirm_d = 1'b1; state_d = S_POLL;
        end else if (tcnt_q == 24'd0) begin
          done_d = 1'b1; err_d = 1'b1; state_d = S_DONE;
        end else begin
          state_d = S_POLL;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset drops both strobes immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      step_q     <= 3'd0;
      op_q       <= 2'd0;
      addr_q     <= 23'd0;
      data_q     <= 16'd0;
      bus_addr_q <= 23'd0;
      bus_wdat_q <= 16'd0;
      bus_we_q   <= 1'b0;
      bus_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      confirm_q  <= 1'b0;
      q7_q       <= 1'b0;
      q5_q       <= 1'b0;
      tcnt_q     <= 24'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      bus_addr_q <= bus_addr_d;
      bus_wdat_q <= bus_wdat_d;
      bus_we_q   <= bus_we_d;
      bus_oe_q   <= bus_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      confirm_q  <= confirm_d;
      q7_q       <= q7_d;
      q5_q       <= q5_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign cmd_ready = ready_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdat  = bus_wdat_q;
  assign bus_we    = bus_we_q;
  assign bus_oe    = bus_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_md_flash_seq.sv
// Bench for md_flash_seq: scoreboard of expected bus writes, poll reads and completions.
module tb_md_flash_seq;
  localparam logic [22:0] A1  = 23'h000555;
  localparam logic [22:0] A2  = 23'h0002AA;
  localparam int          TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [22:0] cmd_addr = 23'd0;
  logic [15:0] cmd_data = 16'd0;
  logic [22:0] bus_addr;
  logic [15:0] bus_wdat;
  logic        bus_we;
  logic        bus_oe;
  logic        bus_ack;
  logic [15:0] bus_rdat;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  md_flash_seq #(.TIMEOUT_CYC(24'd64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .bus_addr(bus_addr), .bus_wdat(bus_wdat), .bus_we(bus_we), .bus_oe(bus_oe),
    .bus_ack(bus_ack), .bus_rdat(bus_rdat),
    .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [38:0] exp_wr_q[$];
  logic [22:0] exp_rd_q[$];
  logic        exp_done_q[$];
  logic [15:0] rd_data_q[$];
  logic [15:0] plan[$];
  int   lat = 2;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   acc_cyc = 0;
  int   done_cyc = 0;
  logic overlap = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
    if (done) done_cyc <= cyc;
  end

  // Flash/bus model: ack each strobe after lat cycles, read data from rd_data_q (default 0).
  initial begin
    int cnt;
    cnt = 0;
    bus_ack = 1'b0;
    bus_rdat = 16'h0000;
    forever begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (rst && (bus_we || bus_oe)) begin
        cnt++;
        if (cnt >= lat) begin
          bus_ack = 1'b1;
          cnt = 0;
          if (bus_oe) begin
            if (rd_data_q.size() > 0) bus_rdat = rd_data_q.pop_front();
            else bus_rdat = 16'h0000;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: compares every completed access and every done pulse against the scoreboard.
  initial begin
    logic [38:0] ew;
    logic [22:0] ea;
    logic        ee;
    forever begin
      @(posedge clk); #2;
      if (bus_we && bus_oe) overlap = 1'b1;
      if (bus_ack && bus_we) begin
        if (exp_wr_q.size() > 0) begin
          ew = exp_wr_q.pop_front();
          chk("bus_write", 64'({bus_addr, bus_wdat}), 64'(ew));
        end else begin
          n_checks++;
          $display("FAIL bus_write_extra actual=%h/%h required=none", bus_addr, bus_wdat);
        end
      end
      if (bus_ack && bus_oe) begin
        if (exp_rd_q.size() > 0) begin
          ea = exp_rd_q.pop_front();
          chk("poll_addr", 64'(bus_addr), 64'(ea));
        end else begin
          n_checks++;
          $display("FAIL poll_read_extra actual=%h required=none", bus_addr);
        end
      end
      if (done) begin
        if (exp_done_q.size() > 0) begin
          ee = exp_done_q.pop_front();
          chk("done_err", 64'(err), 64'(ee));
          chk("done_busy", 64'(busy), 64'd1);
        end else begin
          n_checks++;
          $display("FAIL done_extra actual=1 required=0");
        end
      end
    end
  end

  // Reference model: expected writes, poll reads and final err for one command,
  // using the read values in plan (0x0000 once plan runs out).
  task automatic expect_cmd(input logic [1:0] op, input logic [22:0] a, input logic [15:0] d);
    logic        e7, conf, fin, e;
    logic [15:0] q;
    logic [22:0] pa;
    int          k;
    case (op)
      2'd0: begin
        exp_wr_q.push_back({A1, 16'h00AA}); exp_wr_q.push_back({A2, 16'h0055});
        exp_wr_q.push_back({A1, 16'h00A0}); exp_wr_q.push_back({a, d});
      end
      2'd3: exp_wr_q.push_back({a, 16'h00F0});
      default: begin
        exp_wr_q.push_back({A1, 16'h00AA}); exp_wr_q.push_back({A2, 16'h0055});
        exp_wr_q.push_back({A1, 16'h0080}); exp_wr_q.push_back({A1, 16'h00AA});
        exp_wr_q.push_back({A2, 16'h0055});
        exp_wr_q.push_back(op == 2'd1 ? {a, 16'h0030} : {A1, 16'h0010});
      end
    endcase
    if (op == 2'd3) begin
      exp_done_q.push_back(1'b0);
    end else begin
      e7 = (op == 2'd0) ? d[7] : 1'b1;
      pa = (op == 2'd2) ? A1 : a;
      conf = 1'b0; fin = 1'b0; e = 1'b0; k = 0;
      while (!fin) begin
        q = (k < plan.size()) ? plan[k] : 16'h0000;
        k++;
        exp_rd_q.push_back(pa);
        // Each poll round is one issue cycle, lat wait cycles and one decision cycle;
        // the k-th decision happens k*(lat+2)-1 cycles after polling started.
        if (q[7] == e7) begin e = 1'b0; fin = 1'b1; end
        else if (conf) begin e = 1'b1; fin = 1'b1; end
        else if (q[5]) conf = 1'b1;
        else if (k * (lat + 2) - 1 >= TMO) begin e = 1'b1; fin = 1'b1; end
      end
      exp_done_q.push_back(e);
      for (int j = 0; j < k && j < plan.size(); j++) rd_data_q.push_back(plan[j]);
    end
    plan.delete();
  endtask

  task automatic issue(input logic [1:0] op, input logic [22:0] a, input logic [15:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 500) begin @(negedge clk); k++; end
    if (!cmd_ready) begin
      n_checks++;
      $display("FAIL cmd_ready_wait actual=0 required=1");
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || exp_done_q.size() != 0 || busy)
           && k < 3000) begin
      @(negedge clk); k++;
    end
    chk(nm, 64'({8'(exp_wr_q.size()), 8'(exp_rd_q.size()), 8'(exp_done_q.size()),
                 8'(rd_data_q.size()), 7'd0, busy}), 64'd0);
    exp_wr_q.delete(); exp_rd_q.delete(); exp_done_q.delete(); rd_data_q.delete();
  endtask

  task automatic run(input logic [1:0] op, input logic [22:0] a, input logic [15:0] d,
                     input string nm);
    expect_cmd(op, a, d);
    issue(op, a, d);
    wait_idle(nm);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [22:0] ra;
    logic [15:0] rd, q;
    logic        e7;
    int          k, base;

    #12;
    chk("rst_we", 64'(bus_we), 64'd0);
    chk("rst_oe", 64'(bus_oe), 64'd0);
    chk("rst_addr_wdat", 64'({bus_addr, bus_wdat}), 64'd0);
    chk("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk); rst = 1'b1;

    // T1 program word
    lat = 2;
    plan.push_back(16'h0080); plan.push_back(16'h0080); plan.push_back(16'h1234);
    run(2'd0, 23'h000100, 16'h1234, "t1_drain");
    // T2 sector erase
    plan.push_back(16'h0000); plan.push_back(16'h0080);
    run(2'd1, 23'h010000, 16'h0000, "t2_drain");
    // T3 DQ5 with failed confirm read
    plan.push_back(16'h0020); plan.push_back(16'h0020);
    run(2'd0, 23'h000200, 16'h00FF, "t3_drain");
    // T4 chip erase timeout, flash reads 0x0000 forever
    run(2'd2, 23'h000000, 16'h0000, "t4_drain");

    // T5 reset asserted while the third program write is on the bus
    exp_wr_q.push_back({A1, 16'h00AA}); exp_wr_q.push_back({A2, 16'h0055});
    issue(2'd0, 23'h000100, 16'h1234);
    k = 0;
    while (!(bus_we && bus_wdat == 16'h00A0) && k < 100) begin @(negedge clk); k++; end
    chk("t5_third_write_seen", 64'(bus_we), 64'd1);
    rst = 1'b0;
    #1;
    chk("t5_we_drop", 64'(bus_we), 64'd0);
    chk("t5_busy_drop", 64'(busy), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    wait_idle("t5_drain");
    plan.push_back(16'h0080); plan.push_back(16'h0080); plan.push_back(16'h1234);
    run(2'd0, 23'h000100, 16'h1234, "t5_rerun_drain");

    // T6 reset op, cmd_valid held through busy
    expect_cmd(2'd3, 23'h000000, 16'h0000);
    expect_cmd(2'd3, 23'h012345, 16'h0000);
    base = acc_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_addr = 23'h000000; cmd_data = 16'h0000;
    @(negedge clk);
    cmd_addr = 23'h012345;
    k = 0;
    while (acc_cnt < base + 2 && k < 200) begin @(negedge clk); k++; end
    cmd_valid = 1'b0;
    chk("t6_accepts", 64'(acc_cnt - base), 64'd2);
    chk("t6_accept_after_done", 64'(acc_cyc), 64'(done_cyc + 1));
    wait_idle("t6_drain");

    // Randomized commands
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 23'($urandom);
      rd  = 16'($urandom);
      lat = $urandom_range(1, 3);
      e7  = (rop == 2'd0) ? rd[7] : 1'b1;
      for (int j = 0; j < 6; j++) begin
        q = 16'($urandom);
        if (j == 5) q[7] = e7;
        plan.push_back(q);
      end
      run(rop, ra, rd, "rand_drain");
    end

    chk("strobe_overlap", 64'(overlap), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
